// File: rtl/ctrl_pipeline_pkg.sv
// Shared definitions for the control pipeline: forwarding-select encodings
// and the priority encoder that turns stage hits into a select.
package ctrl_pipeline_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // The MEM result is younger than the WB result, so it wins when both match.
    function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        sel = FWD_NONE;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_pipeline_stage_reg.sv
// One pipeline stage register: asynchronous clear, hold (freeze) and
// bubble (load zero). Hold outranks bubble so a frozen stage keeps its contents.
module ctrl_stage_reg #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_hold,
    input  logic             i_bubble,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (!i_hold) begin
            r_q <= i_bubble ? '0 : i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ctrl_pipeline.sv
// Control-side pipeline: ID/EX, EX/MEM and MEM/WB control registers with
// load-use stall detection, branch flush, memory-stall freeze and EX forwarding.
module ctrl_pipeline
    import ctrl_pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  Branch_i,
    input  logic                  MemtoReg_i,
    input  logic [ALUOP_W-1:0]    ALUOp_i,
    input  logic                  MemWrite_i,
    input  logic                  MemRead_i,
    input  logic                  ALUSrc_i,
    input  logic                  RegWrite_i,
    input  logic [REG_ADDR_W-1:0] RS1addr_i,
    input  logic [REG_ADDR_W-1:0] RS2addr_i,
    input  logic [REG_ADDR_W-1:0] RDaddr_i,
    input  logic                  BranchTaken_i,
    input  logic                  MemStall_i,
    output logic                  Stall_o,
    output logic                  PCWrite_o,
    output logic                  Flush_o,
    output logic [ALUOP_W-1:0]    EX_ALUOp_o,
    output logic                  EX_ALUSrc_o,
    output logic                  MEM_MemRead_o,
    output logic                  MEM_MemWrite_o,
    output logic                  WB_RegWrite_o,
    output logic                  WB_MemtoReg_o,
    output logic [REG_ADDR_W-1:0] WB_RDaddr_o,
    output logic [1:0]            ForwardA_o,
    output logic [1:0]            ForwardB_o
);

    localparam int IDEX_W  = 5 + ALUOP_W + 3 * REG_ADDR_W;
    localparam int EXMEM_W = 4 + REG_ADDR_W;
    localparam int MEMWB_W = 2 + REG_ADDR_W;

    logic [IDEX_W-1:0]     w_idex_d, w_idex_q;
    logic [EXMEM_W-1:0]    w_exmem_d, w_exmem_q;
    logic [MEMWB_W-1:0]    w_memwb_d, w_memwb_q;

    logic                  w_ex_mtr, w_ex_mw, w_ex_mr, w_ex_alusrc, w_ex_rw;
    logic [ALUOP_W-1:0]    w_ex_aluop;
    logic [REG_ADDR_W-1:0] w_ex_rs1, w_ex_rs2, w_ex_rd;
    logic                  w_mem_mtr, w_mem_mr, w_mem_mw, w_mem_rw;
    logic [REG_ADDR_W-1:0] w_mem_rd;
    logic                  w_wb_mtr, w_wb_rw;
    logic [REG_ADDR_W-1:0] w_wb_rd;
    logic                  w_stall;

    // ID -> EX: a load-use hazard replaces the incoming instruction with a bubble
    assign w_idex_d = {MemtoReg_i, ALUOp_i, MemWrite_i, MemRead_i, ALUSrc_i, RegWrite_i,
                       RS1addr_i, RS2addr_i, RDaddr_i};

    ctrl_stage_reg #(.WIDTH(IDEX_W)) u_idex (
        .i_clk(clk_i), .i_rst_n(rst_i), .i_hold(MemStall_i), .i_bubble(w_stall),
        .i_d(w_idex_d), .o_q(w_idex_q)
    );

    assign {w_ex_mtr, w_ex_aluop, w_ex_mw, w_ex_mr, w_ex_alusrc, w_ex_rw,
            w_ex_rs1, w_ex_rs2, w_ex_rd} = w_idex_q;

    // EX -> MEM
    assign w_exmem_d = {w_ex_mtr, w_ex_mr, w_ex_mw, w_ex_rw, w_ex_rd};

    ctrl_stage_reg #(.WIDTH(EXMEM_W)) u_exmem (
        .i_clk(clk_i), .i_rst_n(rst_i), .i_hold(MemStall_i), .i_bubble(1'b0),
        .i_d(w_exmem_d), .o_q(w_exmem_q)
    );

    assign {w_mem_mtr, w_mem_mr, w_mem_mw, w_mem_rw, w_mem_rd} = w_exmem_q;

    // MEM -> WB
    assign w_memwb_d = {w_mem_mtr, w_mem_rw, w_mem_rd};

    ctrl_stage_reg #(.WIDTH(MEMWB_W)) u_memwb (
        .i_clk(clk_i), .i_rst_n(rst_i), .i_hold(MemStall_i), .i_bubble(1'b0),
        .i_d(w_memwb_d), .o_q(w_memwb_q)
    );

    assign {w_wb_mtr, w_wb_rw, w_wb_rd} = w_memwb_q;

    // A load to x0 produces nothing anyone can depend on, so it never stalls.
    assign w_stall = w_ex_mr & (w_ex_rd != '0) &
                     ((w_ex_rd == RS1addr_i) | (w_ex_rd == RS2addr_i));

    assign Stall_o   = w_stall;
    assign PCWrite_o = ~(w_stall | MemStall_i);
    assign Flush_o   = Branch_i & BranchTaken_i & ~w_stall & ~MemStall_i;

    assign ForwardA_o = fwd_select(w_mem_rw & (w_mem_rd != '0) & (w_mem_rd == w_ex_rs1),
                                   w_wb_rw  & (w_wb_rd  != '0) & (w_wb_rd  == w_ex_rs1));
    assign ForwardB_o = fwd_select(w_mem_rw & (w_mem_rd != '0) & (w_mem_rd == w_ex_rs2),
                                   w_wb_rw  & (w_wb_rd  != '0) & (w_wb_rd  == w_ex_rs2));

    assign EX_ALUOp_o     = w_ex_aluop;
    assign EX_ALUSrc_o    = w_ex_alusrc;
    assign MEM_MemRead_o  = w_mem_mr;
    assign MEM_MemWrite_o = w_mem_mw;
    assign WB_RegWrite_o  = w_wb_rw;
    assign WB_MemtoReg_o  = w_wb_mtr;
    assign WB_RDaddr_o    = w_wb_rd;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed hazard/forward/stall scenarios plus random
// traffic, compared every cycle against a three-slot instruction-queue model.
module tb_ctrl_pipeline;

    typedef struct packed {
        logic       mtr;
        logic [1:0] aluop;
        logic       mw;
        logic       mr;
        logic       alusrc;
        logic       rw;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ins_t;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       Branch_i, BranchTaken_i, MemStall_i;
    ins_t       id;
    logic       Stall_o, PCWrite_o, Flush_o;
    logic [1:0] EX_ALUOp_o;
    logic       EX_ALUSrc_o, MEM_MemRead_o, MEM_MemWrite_o, WB_RegWrite_o, WB_MemtoReg_o;
    logic [4:0] WB_RDaddr_o;
    logic [1:0] ForwardA_o, ForwardB_o;

    int errors = 0;
    int checks = 0;

    // Model: slot 0 = instruction in EX, 1 = MEM, 2 = WB
    ins_t st [3];

    always #5 clk = ~clk;

    ctrl_pipeline #(.REG_ADDR_W(5), .ALUOP_W(2)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .Branch_i(Branch_i), .MemtoReg_i(id.mtr), .ALUOp_i(id.aluop),
        .MemWrite_i(id.mw), .MemRead_i(id.mr), .ALUSrc_i(id.alusrc),
        .RegWrite_i(id.rw), .RS1addr_i(id.rs1), .RS2addr_i(id.rs2), .RDaddr_i(id.rd),
        .BranchTaken_i(BranchTaken_i), .MemStall_i(MemStall_i),
        .Stall_o(Stall_o), .PCWrite_o(PCWrite_o), .Flush_o(Flush_o),
        .EX_ALUOp_o(EX_ALUOp_o), .EX_ALUSrc_o(EX_ALUSrc_o),
        .MEM_MemRead_o(MEM_MemRead_o), .MEM_MemWrite_o(MEM_MemWrite_o),
        .WB_RegWrite_o(WB_RegWrite_o), .WB_MemtoReg_o(WB_MemtoReg_o),
        .WB_RDaddr_o(WB_RDaddr_o), .ForwardA_o(ForwardA_o), .ForwardB_o(ForwardB_o)
    );

    function automatic ins_t mk(input logic mtr, input logic [1:0] aluop, input logic mw,
                                input logic mr, input logic alusrc, input logic rw,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        ins_t t;
        t.mtr = mtr; t.aluop = aluop; t.mw = mw; t.mr = mr; t.alusrc = alusrc; t.rw = rw;
        t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        return t;
    endfunction

    function automatic logic m_stall();
        return st[0].mr && (st[0].rd != 5'd0) && (st[0].rd == id.rs1 || st[0].rd == id.rs2);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (st[1].rw && st[1].rd != 5'd0 && st[1].rd == src) return 2'd2;
        if (st[2].rw && st[2].rd != 5'd0 && st[2].rd == src) return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic s;
        s = m_stall();
        chk("Stall_o",        32'(Stall_o),        32'(s));
        chk("PCWrite_o",      32'(PCWrite_o),      32'(!(s || MemStall_i)));
        chk("Flush_o",        32'(Flush_o),        32'(Branch_i && BranchTaken_i && !s && !MemStall_i));
        chk("EX_ALUOp_o",     32'(EX_ALUOp_o),     32'(st[0].aluop));
        chk("EX_ALUSrc_o",    32'(EX_ALUSrc_o),    32'(st[0].alusrc));
        chk("MEM_MemRead_o",  32'(MEM_MemRead_o),  32'(st[1].mr));
        chk("MEM_MemWrite_o", 32'(MEM_MemWrite_o), 32'(st[1].mw));
        chk("WB_RegWrite_o",  32'(WB_RegWrite_o),  32'(st[2].rw));
        chk("WB_MemtoReg_o",  32'(WB_MemtoReg_o),  32'(st[2].mtr));
        chk("WB_RDaddr_o",    32'(WB_RDaddr_o),    32'(st[2].rd));
        chk("ForwardA_o",     32'(ForwardA_o),     32'(m_fwd(st[0].rs1)));
        chk("ForwardB_o",     32'(ForwardB_o),     32'(m_fwd(st[0].rs2)));
    endtask

    // Inputs are set at posedge+1; outputs are compared at posedge+4.
    task automatic eval();
        #3;
        compare_all();
    endtask

    task automatic tick();
        logic s;
        s = m_stall();
        @(posedge clk);
        if (!MemStall_i) begin
            st[2] = st[1];
            st[1] = st[0];
            st[0] = s ? ins_t'('0) : id;
        end
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) st[i] = '0;
    endtask

    task automatic fwd_seq(input logic rw2, input logic [4:0] rd1, input logic [4:0] rd2,
                           input logic [1:0] exp);
        id = mk(0, 2'd0, 0, 0, 0, 1, 5'd0, 5'd0, rd1);   eval(); tick();
        id = mk(0, 2'd0, 0, 0, 0, rw2, 5'd0, 5'd0, rd2); eval(); tick();
        id = mk(0, 2'd1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd9);  eval(); tick();
        id = '0;
        eval();
        chk("fwd_A_literal", 32'(ForwardA_o), 32'(exp));
        chk("fwd_B_literal", 32'(ForwardB_o), 32'(exp));
        tick();
    endtask

    initial begin
        rst_i = 1'b0; id = '0; Branch_i = 1'b0; BranchTaken_i = 1'b0; MemStall_i = 1'b0;
        model_clear();
        #1;
        chk("rst_Stall",   32'(Stall_o), 0);
        chk("rst_PCWrite", 32'(PCWrite_o), 1);
        chk("rst_FwdA",    32'(ForwardA_o), 0);
        chk("rst_WB_RW",   32'(WB_RegWrite_o), 0);
        compare_all();
        @(posedge clk); #1;
        rst_i = 1'b1;
        eval();
        chk("post_rst_WB_RD", 32'(WB_RDaddr_o), 0);
        chk("post_rst_FwdB",  32'(ForwardB_o), 0);
        tick();

        // Load-use: load x5, then a consumer of x5
        id = mk(1, 2'd0, 0, 1, 1, 1, 5'd0, 5'd0, 5'd5); eval(); tick();
        id = mk(0, 2'd2, 0, 0, 1, 1, 5'd5, 5'd0, 5'd6); eval();
        chk("lu_Stall",   32'(Stall_o), 1);
        chk("lu_PCWrite", 32'(PCWrite_o), 0);
        tick();
        eval();
        chk("lu_Stall_once", 32'(Stall_o), 0);
        chk("lu_bubble_op",  32'(EX_ALUOp_o), 0);
        chk("lu_bubble_src", 32'(EX_ALUSrc_o), 0);
        tick();
        id = '0;
        eval();
        chk("lu_load_in_WB", 32'(WB_RegWrite_o), 1);
        tick();
        eval();
        chk("lu_bubble_WB", 32'(WB_RegWrite_o), 0);
        tick();

        // Memory stall with a store sitting in MEM
        id = mk(0, 2'd0, 1, 0, 1, 0, 5'd1, 5'd2, 5'd0); eval(); tick();
        id = '0; eval(); tick();
        MemStall_i = 1'b1;
        id = mk(0, 2'd3, 0, 0, 0, 1, 5'd1, 5'd1, 5'd4);
        repeat (3) begin
            eval();
            chk("ms_store_held", 32'(MEM_MemWrite_o), 1);
            chk("ms_PCWrite",    32'(PCWrite_o), 0);
            tick();
        end
        MemStall_i = 1'b0;
        eval(); tick();
        id = '0;
        eval();
        chk("ms_resume_EX", 32'(EX_ALUOp_o), 3);
        tick();

        // Forwarding priority and x0
        fwd_seq(1'b1, 5'd3, 5'd3, 2'b10);
        fwd_seq(1'b0, 5'd3, 5'd3, 2'b01);
        fwd_seq(1'b1, 5'd0, 5'd0, 2'b00);

        // Branch flush, suppressed by memory stall and by load-use
        Branch_i = 1'b1; BranchTaken_i = 1'b1;
        eval(); chk("br_flush", 32'(Flush_o), 1); tick();
        MemStall_i = 1'b1;
        eval(); chk("br_flush_ms", 32'(Flush_o), 0); tick();
        MemStall_i = 1'b0; Branch_i = 1'b0;
        id = mk(1, 2'd0, 0, 1, 1, 1, 5'd0, 5'd0, 5'd4); eval(); tick();
        Branch_i = 1'b1;
        id = mk(0, 2'd0, 0, 0, 0, 0, 5'd4, 5'd0, 5'd0);
        eval();
        chk("br_lu_stall", 32'(Stall_o), 1);
        chk("br_flush_lu", 32'(Flush_o), 0);
        tick();
        Branch_i = 1'b0; BranchTaken_i = 1'b0; id = '0;
        eval(); tick();

        // Memory stall coinciding with a load-use hazard
        id = mk(1, 2'd0, 0, 1, 1, 1, 5'd0, 5'd0, 5'd7); eval(); tick();
        id = mk(0, 2'd1, 0, 0, 0, 1, 5'd0, 5'd7, 5'd8);
        MemStall_i = 1'b1;
        repeat (2) begin
            eval();
            chk("msl_stall_held", 32'(Stall_o), 1);
            tick();
        end
        MemStall_i = 1'b0;
        eval(); chk("msl_stall_one", 32'(Stall_o), 1); tick();
        eval(); chk("msl_stall_done", 32'(Stall_o), 0); tick();
        id = '0; eval(); tick();

        // Reset asserted while a load-use stall is active
        id = mk(1, 2'd0, 0, 1, 1, 1, 5'd0, 5'd0, 5'd8); eval(); tick();
        id = mk(0, 2'd0, 0, 0, 0, 1, 5'd8, 5'd0, 5'd9);
        eval();
        chk("rs_stall_pre", 32'(Stall_o), 1);
        rst_i = 1'b0;
        model_clear();
        #1;
        chk("rs_stall_cleared", 32'(Stall_o), 0);
        compare_all();
        @(posedge clk); #1;
        rst_i = 1'b1;
        id = '0;
        eval(); tick();

        // Random traffic; small address range to provoke hazards and forwards
        repeat (3000) begin
            id = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            Branch_i      = 1'($urandom_range(0, 1));
            BranchTaken_i = 1'($urandom_range(0, 1));
            MemStall_i    = ($urandom_range(0, 4) == 0);
            eval();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
